// File: rtl/rst_seq_pkg.sv
// Shared encodings for the central reset sequencer: FSM states and reset-cause codes.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAssert  = 2'd1,
        StRelease = 2'd2,
        StDone    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CausePor = 2'd0,
        CauseSw  = 2'd1,
        CauseWdt = 2'd2
    } cause_e;

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable down-counter with zero and last-count flags; used for the hold and gap timers.
module rst_seq_cnt #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o,
    output logic             last_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == Width'(1));

endmodule

// File: rtl/rst_seq_ctrl.sv
// Central reset sequencer: asserts participating domains, holds, then releases them in index
// order with a programmable gap. Power-on, software and watchdog causes share one sequence.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int unsigned NDOM = 22,
    parameter int unsigned CNTW = 8,
    parameter int unsigned HOLD = 16,
    parameter int unsigned GAP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            swrst_req,
    input  logic            wdt_req,
    input  logic [NDOM-1:0] rstmsk,
    output logic [NDOM-1:0] orst_,
    output logic            busy,
    output logic            done,
    output logic [1:0]      cause
);

    localparam int unsigned PtrW = (NDOM > 1) ? $clog2(NDOM) : 1;
    localparam logic [CNTW-1:0] HoldLoad = CNTW'(HOLD - 1);
    localparam logic [CNTW-1:0] GapLoad  = CNTW'(GAP - 1);

    state_e          state_q, state_d;
    cause_e          cause_q, cause_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [NDOM-1:0] orst_q, orst_d;
    logic            scan_end_q, scan_end_d;
    logic            por_flag_q, por_flag_d;
    logic            pend_sw_q, pend_sw_d;
    logic            pend_wdt_q, pend_wdt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [NDOM-1:0] part;
    logic            hold_load, hold_dec, hold_zero, hold_last;
    logic            gap_load, gap_dec, gap_zero, unused_gap_last;
    logic [CNTW-1:0] gap_load_val;
    logic            release_fire, enter_wdt, enter_sw;

    // A power-on sequence ignores the mask entirely.
    assign part = por_flag_q ? {NDOM{1'b1}} : ~rstmsk;

    rst_seq_cnt #(.Width(CNTW)) u_hold_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (hold_load),
        .load_val_i (HoldLoad),
        .dec_i      (hold_dec),
        .zero_o     (hold_zero),
        .last_o     (hold_last)
    );

    rst_seq_cnt #(.Width(CNTW)) u_gap_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (gap_load),
        .load_val_i (gap_load_val),
        .dec_i      (gap_dec),
        .zero_o     (gap_zero),
        .last_o     (unused_gap_last)
    );

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        ptr_d        = ptr_q;
        scan_end_d   = scan_end_q;
        por_flag_d   = por_flag_q;
        pend_sw_d    = pend_sw_q;
        pend_wdt_d   = pend_wdt_q;
        hold_load    = 1'b0;
        hold_dec     = 1'b0;
        gap_load     = 1'b0;
        gap_load_val = '0;
        gap_dec      = 1'b0;
        release_fire = 1'b0;
        enter_wdt    = 1'b0;
        enter_sw     = 1'b0;

        if (swrst_req && (state_q != StIdle)) begin
            pend_sw_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (wdt_req) begin
                    enter_wdt = 1'b1;
                end else if (swrst_req) begin
                    enter_sw = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StAssert: begin
                if (wdt_req && !por_flag_q) begin
                    enter_wdt = 1'b1;
                end else begin
                    if (wdt_req) begin
                        pend_wdt_d = 1'b1;
                    end
                    // Zero only occurs straight out of power-on reset: that edge counts as edge 1.
                    if (hold_zero) begin
                        hold_load = 1'b1;
                    end else if (hold_last) begin
                        state_d    = StRelease;
                        ptr_d      = '0;
                        scan_end_d = 1'b0;
                        gap_load   = 1'b1;
                    end else begin
                        hold_dec = 1'b1;
                    end
                end
            end
            StRelease: begin
                if (wdt_req && !por_flag_q) begin
                    enter_wdt = 1'b1;
                end else begin
                    if (wdt_req) begin
                        pend_wdt_d = 1'b1;
                    end
                    if (scan_end_q) begin
                        state_d    = StDone;
                        por_flag_d = 1'b0;
                    end else if (!gap_zero) begin
                        gap_dec = 1'b1;
                    end else begin
                        // Masked indices cost one cycle each and never load the gap.
                        if (part[ptr_q]) begin
                            release_fire = 1'b1;
                            gap_load     = 1'b1;
                            gap_load_val = GapLoad;
                        end
                        if (ptr_q == PtrW'(NDOM - 1)) begin
                            scan_end_d = 1'b1;
                        end else begin
                            ptr_d = ptr_q + PtrW'(1);
                        end
                    end
                end
            end
            StDone: begin
                if (wdt_req || pend_wdt_q) begin
                    enter_wdt = 1'b1;
                end else if (pend_sw_q || swrst_req) begin
                    enter_sw = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase

        if (enter_wdt) begin
            state_d    = StAssert;
            cause_d    = CauseWdt;
            hold_load  = 1'b1;
            hold_dec   = 1'b0;
            pend_wdt_d = 1'b0;
        end else if (enter_sw) begin
            state_d   = StAssert;
            cause_d   = CauseSw;
            hold_load = 1'b1;
            hold_dec  = 1'b0;
            pend_sw_d = 1'b0;
        end

        orst_d = orst_q;
        if (state_d == StAssert) begin
            orst_d = orst_q & ~part;
        end else if (release_fire) begin
            orst_d[ptr_q] = 1'b1;
        end

        busy_d = (state_d == StAssert) || (state_d == StRelease);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StAssert;
            cause_q    <= CausePor;
            ptr_q      <= '0;
            orst_q     <= '0;
            scan_end_q <= 1'b0;
            por_flag_q <= 1'b1;
            pend_sw_q  <= 1'b0;
            pend_wdt_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            ptr_q      <= ptr_d;
            orst_q     <= orst_d;
            scan_end_q <= scan_end_d;
            por_flag_q <= por_flag_d;
            pend_sw_q  <= pend_sw_d;
            pend_wdt_q <= pend_wdt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign orst_ = orst_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign cause = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: table of whole sequences plus abort/pending/reset cases.
module tb_rst_seq_ctrl;

    localparam int NDOM = 22;
    localparam int HOLD = 16;
    localparam int GAP  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            swrst_req;
    logic            wdt_req;
    logic [NDOM-1:0] rstmsk;
    logic [NDOM-1:0] orst_;
    logic            busy;
    logic            done;
    logic [1:0]      cause;

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .NDOM (NDOM),
        .CNTW (8),
        .HOLD (HOLD),
        .GAP  (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .swrst_req (swrst_req),
        .wdt_req   (wdt_req),
        .rstmsk    (rstmsk),
        .orst_     (orst_),
        .busy      (busy),
        .done      (done),
        .cause     (cause)
    );

    typedef struct packed {
        logic [NDOM-1:0] orst;
        logic            busy;
        logic            done;
        logic [1:0]      cause;
    } obs_t;

    typedef struct {
        string           name;
        logic            por;
        logic            sw;
        logic            wdt;
        logic [NDOM-1:0] msk;
        logic [1:0]      cause;
    } vec_t;

    obs_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Release edge of index i: first at HOLD+1, GAP after each release, 1 after each skip.
    function automatic int done_edge(logic [NDOM-1:0] msk, logic por);
        int t;
        int last;
        t    = HOLD + 1;
        last = t;
        for (int i = 0; i < NDOM; i++) begin
            last = t;
            t    = t + ((por || !msk[i]) ? GAP : 1);
        end
        return last + 1;
    endfunction

    function automatic obs_t exp_at(int n, logic [NDOM-1:0] msk, logic por, logic [1:0] c,
                                    logic [NDOM-1:0] prev);
        obs_t e;
        int   t;
        int   de;
        t  = HOLD + 1;
        de = done_edge(msk, por);
        e.orst = prev;
        for (int i = 0; i < NDOM; i++) begin
            if (por || !msk[i]) begin
                e.orst[i] = (n >= t);
                t = t + GAP;
            end else begin
                t = t + 1;
            end
        end
        e.busy  = (n < de);
        e.done  = (n == de);
        e.cause = c;
        return e;
    endfunction

    task automatic check(input string name, input int n, input obs_t e);
        obs_t a;
        a = {orst_, busy, done, cause};
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s edge %0d: got orst_=%h busy=%b done=%b cause=%0d, want orst_=%h busy=%b done=%b cause=%0d",
                     name, n, a.orst, a.busy, a.done, a.cause, e.orst, e.busy, e.done, e.cause);
        end
    endtask

    // Edge 1 is the next rising edge; the caller has already set up whatever triggers it.
    task automatic run_seq(input string name, input logic [NDOM-1:0] msk, input logic por,
                           input logic [1:0] c, input logic [NDOM-1:0] prev, input int n_last,
                           input int sw_pulses);
        obs_t e;
        for (int n = 1; n <= n_last; n++) begin
            sb_q.push_back(exp_at(n, msk, por, c, prev));
            @(posedge clk);
            #1;
            swrst_req = 1'b0;
            wdt_req   = 1'b0;
            e = sb_q.pop_front();
            check(name, n, e);
            if ((n % 20 == 9) && (n / 20 >= 1) && (n / 20 <= sw_pulses)) begin
                swrst_req = 1'b1;
            end
        end
    endtask

    task automatic do_por(input string name, input logic [NDOM-1:0] msk);
        obs_t r;
        rst       = 1'b1;
        rstmsk    = msk;
        swrst_req = 1'b0;
        wdt_req   = 1'b0;
        @(negedge clk);
        r = '{orst: '0, busy: 1'b1, done: 1'b0, cause: 2'd0};
        check({name, "_reset"}, 0, r);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t            vecs[4];
        logic [NDOM-1:0] prev;
        logic [NDOM-1:0] all1;
        obs_t            r;
        int              de;

        rst       = 1'b1;
        swrst_req = 1'b0;
        wdt_req   = 1'b0;
        rstmsk    = '0;
        all1      = '1;
        prev      = '0;

        vecs[0] = '{name: "por_nomask", por: 1'b1, sw: 1'b0, wdt: 1'b0, msk: 22'h000000, cause: 2'd0};
        vecs[1] = '{name: "por_allmask", por: 1'b1, sw: 1'b0, wdt: 1'b0, msk: 22'h3FFFFF, cause: 2'd0};
        vecs[2] = '{name: "sw_mask6", por: 1'b0, sw: 1'b1, wdt: 1'b0, msk: 22'h000006, cause: 2'd1};
        vecs[3] = '{name: "wdt_idle", por: 1'b0, sw: 1'b0, wdt: 1'b1, msk: 22'h300F00, cause: 2'd2};

        foreach (vecs[v]) begin
            if (vecs[v].por) begin
                do_por(vecs[v].name, vecs[v].msk);
                prev = '0;
            end else begin
                rstmsk = vecs[v].msk;
                @(negedge clk);
                swrst_req = vecs[v].sw;
                wdt_req   = vecs[v].wdt;
            end
            de = done_edge(vecs[v].msk, vecs[v].por);
            run_seq(vecs[v].name, vecs[v].msk, vecs[v].por, vecs[v].cause, prev, de + 1, 0);
            prev = exp_at(de + 1, vecs[v].msk, vecs[v].por, vecs[v].cause, prev).orst;
        end

        // Watchdog one cycle after domain 5 is released aborts the software sequence.
        rstmsk = '0;
        @(negedge clk);
        swrst_req = 1'b1;
        run_seq("sw_pre_abort", '0, 1'b0, 2'd1, prev, HOLD + 1 + 5 * GAP, 0);
        wdt_req = 1'b1;
        run_seq("wdt_abort", '0, 1'b0, 2'd2, prev, done_edge('0, 1'b0) + 1, 0);

        // Three software pulses during RELEASE collapse into one follow-on sequence.
        @(negedge clk);
        swrst_req = 1'b1;
        run_seq("sw_pend_first", '0, 1'b0, 2'd1, all1, done_edge('0, 1'b0), 3);
        run_seq("sw_pend_replay", '0, 1'b0, 2'd1, all1, done_edge('0, 1'b0) + 1, 0);

        // Reset mid-RELEASE clears outputs without a clock edge, then POR replays.
        do_por("por_mid", '0);
        run_seq("por_mid", '0, 1'b1, 2'd0, '0, HOLD + 1 + 10 * GAP, 0);
        #2;
        rst = 1'b1;
        #1;
        r = '{orst: '0, busy: 1'b1, done: 1'b0, cause: 2'd0};
        check("async_rst", 0, r);
        @(negedge clk);
        rst = 1'b0;
        run_seq("por_after_rst", '0, 1'b1, 2'd0, '0, done_edge('0, 1'b1) + 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
